// File: rtl/demux3_32b.sv
// demux3_32b: registered 1-to-3 stream demultiplexer with per-lane holding registers and saturating discard counter
module demux3_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [7:0]       drop_count
);
  logic [3:0] blocked;
  logic       accept;
  assign blocked  = {1'b0, out_valid & ~out_ready};
  assign in_ready = !blocked[control];
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid  <= '0;
      out0_data  <= '0;
      out1_data  <= '0;
      out2_data  <= '0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (accept && control == 2'(i)) out_valid[i] <= 1'b1;
        else if (out_ready[i]) out_valid[i] <= 1'b0;
      if (accept && control == 2'd0) out0_data <= in_data;
      if (accept && control == 2'd1) out1_data <= in_data;
      if (accept && control == 2'd2) out2_data <= in_data;
      if (accept && control == 2'd3 && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_demux3_32b.sv
// tb_demux3_32b: directed self-checking bench for demux3_32b
module tb_demux3_32b;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [1:0]  control;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0_data, out1_data, out2_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [7:0]  drop_count;
  int n = 0;
  int fails = 0;

  demux3_32b #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .control(control),
    .in_valid(in_valid), .in_ready(in_ready), .out0_data(out0_data),
    .out1_data(out1_data), .out2_data(out2_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d);
    in_valid = v;
    control  = c;
    in_data  = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 3'b111;
    drive(1'b1, 2'b01, 32'hDEAD_BEEF);
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_d1", out1_data, 0);
    chk("rst_d2", out2_data, 0);
    chk("rst_drop", 32'(drop_count), 0);

    drive(1'b1, 2'b00, 32'h0000_0000);
    chk("steer_rdy0", 32'(in_ready), 1);
    tick();
    chk("steer_v0", 32'(out_valid), 32'b001);
    chk("steer_d0", out0_data, 32'h0);
    drive(1'b1, 2'b01, 32'h5555_5555);
    chk("steer_rdy1", 32'(in_ready), 1);
    tick();
    chk("steer_v1", 32'(out_valid), 32'b010);
    chk("steer_d1", out1_data, 32'h5555_5555);
    drive(1'b1, 2'b10, 32'hFFFF_FFFF);
    chk("steer_rdy2", 32'(in_ready), 1);
    tick();
    chk("steer_v2", 32'(out_valid), 32'b100);
    chk("steer_d2", out2_data, 32'hFFFF_FFFF);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("steer_drain", 32'(out_valid), 0);

    out_ready = 3'b101;
    drive(1'b1, 2'b01, 32'hA);
    chk("bp_rdyA", 32'(in_ready), 1);
    tick();
    chk("bp_vA", 32'(out_valid), 32'b010);
    chk("bp_dA", out1_data, 32'hA);
    drive(1'b1, 2'b01, 32'hB);
    chk("bp_stallB", 32'(in_ready), 0);
    tick();
    chk("bp_holdA", out1_data, 32'hA);
    chk("bp_vhold", 32'(out_valid), 32'b010);
    drive(1'b1, 2'b00, 32'hC);
    chk("bp_rdyC", 32'(in_ready), 1);
    tick();
    chk("bp_vC", 32'(out_valid), 32'b011);
    chk("bp_dC", out0_data, 32'hC);
    chk("bp_stillA", out1_data, 32'hA);
    out_ready = 3'b111;
    drive(1'b1, 2'b01, 32'hB);
    chk("bp_rdyB", 32'(in_ready), 1);
    tick();
    chk("bp_dB", out1_data, 32'hB);
    chk("bp_vB", 32'(out_valid), 32'b010);
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("bp_drain", 32'(out_valid), 0);

    out_ready = 3'b100;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 2'b10, 32'(k));
      chk("str_rdy", 32'(in_ready), 1);
      tick();
      chk("str_v", 32'(out_valid), 32'b100);
      chk("str_d", out2_data, 32'(k));
    end
    drive(1'b0, 2'b00, 32'h0);
    tick();
    chk("str_drain", 32'(out_valid), 0);

    out_ready = 3'b000;
    for (int k = 1; k <= 260; k++) begin
      drive(1'b1, 2'b11, 32'(k * 3));
      chk("drop_rdy", 32'(in_ready), 1);
      tick();
      chk("drop_v", 32'(out_valid), 0);
      chk("drop_cnt", 32'(drop_count), (k > 255) ? 255 : k);
    end

    drive(1'b1, 2'b00, 32'h11); tick();
    drive(1'b1, 2'b01, 32'h22); tick();
    drive(1'b1, 2'b10, 32'h33); tick();
    chk("mid_full", 32'(out_valid), 32'b111);
    chk("mid_full_d2", out2_data, 32'h33);
    out_ready = 3'b001;
    reset = 1'b1;
    drive(1'b1, 2'b00, 32'h44);
    chk("mid_rdy", 32'(in_ready), 1);
    tick();
    reset = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    chk("mid_v", 32'(out_valid), 0);
    chk("mid_d0", out0_data, 0);
    chk("mid_d1", out1_data, 0);
    chk("mid_d2", out2_data, 0);
    chk("mid_drop", 32'(drop_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/demux3_32b.md
# demux3_32b

Registered 1-to-3 demultiplexer: the distribution-side counterpart of the 3-input word selector in the datapath. It accepts one word per handshake on a single input stream and steers it to one of three output streams selected by `control`. Each output has a one-entry holding register with valid/ready flow control, so a stalled consumer blocks only its own lane. Words sent with `control = 2'b11` are consumed and discarded, and a saturating counter records them.

## Interface
- `WIDTH`, 32, data word width in bits.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `in_data`  in  WIDTH  input word.
- `control`  in  2  destination: 00→out0, 01→out1, 10→out2, 11→discard.
- `in_valid`  in  1  `in_data`/`control` valid.
- `in_ready`  out  1  input word accepted this cycle when high with `in_valid`.
- `out0_data`, `out1_data`, `out2_data`  out  WIDTH each  lane holding registers.
- `out_valid`  out  3  bit i: lane i holds a word.
- `out_ready`  in  3  bit i: lane i consumer takes the word this cycle.
- `drop_count`  out  8  number of discarded words, saturating at 255.

## Operation
- Accept = `in_valid && in_ready` (rising edge). Lane transfer i = `out_valid[i] && out_ready[i]`.
- `in_ready` is combinational and has no registered path:
  - For `control` 0..2 it equals `!out_valid[control] || out_ready[control]`.
  - For `control = 11` it is constant 1.
- Lane i state update each edge:
  - Accept with `control == i`: `outi_data <= in_data` and `out_valid[i] <= 1`. This holds even if lane i transfers in the same cycle; the old word leaves and the new word loads.
  - Otherwise, transfer on lane i: `out_valid[i] <= 0` and `outi_data` holds its stale value.
  - Otherwise the lane holds.
- Accept with `control = 11` increments `drop_count` when it is below 255; at 255 the counter holds. No lane changes.
- Lanes are independent. A full, stalled lane deasserts `in_ready` only while `control` selects it.
- At most one lane loads per cycle. A word is never duplicated, never dropped on lanes 0..2, and lane order is preserved.
- Producer rule: once `in_valid` is high, `in_valid`, `in_data` and `control` stay stable until accepted. Behaviour under a violation is undefined, but it must not corrupt any other lane.
- `out_ready[i]` while `out_valid[i] = 0` has no effect.

## Timing
- Reset (synchronous, `reset = 1` at an edge) sets:
  - `out_valid <= 3'b000`
  - `out0_data`, `out1_data`, `out2_data <= 0`
  - `drop_count <= 0`
- Reset has priority over a simultaneous accept or transfer. Words held mid-operation are lost.
- During reset, `in_ready` still follows the combinational rule using the pre-reset `out_valid`. Any accept in the reset cycle is discarded and not counted.
- Latency: a word accepted at edge N appears with `out_valid[i] = 1` immediately after edge N, so it is available for transfer at edge N+1.
- Throughput: one word per cycle per lane when `out_ready[i]` is held high. An aggregate of one word per cycle is sustained across alternating lanes.
- Full lane with `out_ready[i] = 0`: `in_ready = 0` while `control` selects that lane, and the producer stalls.
- Full lane with `out_ready[i] = 1`: the same-cycle replace is lossless.
- `drop_count` wrap-around is forbidden; the counter saturates.

## Test plan
- **Reset:** drive garbage inputs and pulse reset for 2 cycles. Required: `out_valid = 000`, all data 0, `drop_count = 0`.
- **Steering:** with `out_ready = 111`, send `0x0000_0000`/00, `0x5555_5555`/01, `0xFFFF_FFFF`/10 on consecutive cycles. Required:
  - each value appears on its own lane one cycle after its accept;
  - `out_valid` pulses `001`, `010`, `100`;
  - `in_ready` is constantly 1.
- **Backpressure:** hold `out_ready[1] = 0` and send `0xA`/01 then `0xB`/01. Required:
  - `0xA` is held;
  - `in_ready = 0` while `0xB` waits;
  - sending `0xC`/00 after `0xB` is withdrawn still succeeds;
  - raising `out_ready[1]` for one cycle accepts `0xB` in that same cycle, `out1_data` reads `0xB` next cycle, and `0xA` was transferred.
- **Streaming:** keep `out_ready[2] = 1` and send 8 words 1..8 back-to-back on 10. Required: `out_valid[2]` stays high for 8 cycles and `out2_data` reads 1..8 in order.
- **Discard saturation:** send 260 words with `control = 11`. Required: `in_ready` is always 1, `drop_count` reaches 255 and holds, and no `out_valid` bit rises.
- **Mid-operation reset:** fill all three lanes with `out_ready = 000`, then assert reset together with an accept on lane 0. Required: after the edge `out_valid = 000`, data is 0 and `drop_count = 0`.
